alu_byte_serial_sequencer: RTL



---
 rtl/alu_byte_serial_sequencer.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_byte_serial_sequencer.sv
// alu_byte_serial_sequencer
//
// Multi-cycle 32-bit integer ALU stage. One 8-bit look-ahead carry adder
// slice is reused across the four operand bytes, LSB first. The carry
// between bytes is kept in a single flop. The stage accepts work with a
// start/ready handshake and hands results on with a valid/ready handshake.
//
// Optional feature macro: ALU_SEQ_SLT_EN
//   defined   : opcodes 6 (SLT) and 7 (SLTU) produce a 0/1 compare result.
//   undefined : opcodes 6 and 7 still run the full sequence, but they
//               return result 0 with zero=1, carry=0 and overflow=0.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   start_in     in   1   request, accepted when ready_out=1
//   op_in        in   3   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU
//   A_in         in   32  operand A, sampled at accept
//   B_in         in   32  operand B, sampled at accept
//   ready_out    out  1   high in IDLE
//   result_out   out  32  registered result
//   valid_out    out  1   result and flags valid
//   ready_in     in   1   downstream takes the result
//   zero_out     out  1   result_out == 0
//   carry_out    out  1   carry out of the top bit (ADD/SUB/SLT/SLTU)
//   overflow_out out  1   signed overflow (ADD/SUB/SLT)

module bit8_look_ahead_carry_adder (
  input  logic [7:0] A_in,
  input  logic [7:0] B_in,
  input  logic       C_in,
  output logic [7:0] S_out,
  output logic       C_out,
  output logic [7:0] AND_out,
  output logic [7:0] OR_out,
  output logic [7:0] XOR_out
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carries;

  assign gen     = A_in & B_in;
  assign prop    = A_in ^ B_in;
  assign AND_out = gen;
  assign OR_out  = A_in | B_in;
  assign XOR_out = prop;

  // Each carry is formed directly as a sum of products of the generate and
  // propagate terms, so no carry depends on a lower carry signal.
  always_comb begin
    logic cl;
    logic term;
    carries = '0;
    for (int i = 0; i <= 8; i++) begin
      cl = C_in;
      for (int j = 0; j < i; j++) cl = cl & prop[j];
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int k = j + 1; k < i; k++) term = term & prop[k];
        cl = cl | term;
      end
      carries[i] = cl;
    end
  end

  assign S_out = prop ^ carries[7:0];
  assign C_out = carries[8];

endmodule

module alu_byte_serial_sequencer #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic [2:0]             op_in,
  input  logic [8*NUM_BYTES-1:0] A_in,
  input  logic [8*NUM_BYTES-1:0] B_in,
  output logic                   ready_out,
  output logic [8*NUM_BYTES-1:0] result_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   zero_out,
  output logic                   carry_out,
  output logic                   overflow_out
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     opA_q, opA_d;
  logic [W-1:0]     opB_q, opB_d;
  logic [2:0]       opCode_q, opCode_d;
  logic [IDX_W-1:0] byteIdx_q, byteIdx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     result_q, result_d;
  logic             valid_q, valid_d;
  logic             zeroFlag_q, zeroFlag_d;
  logic             carryFlag_q, carryFlag_d;
  logic             ovfFlag_q, ovfFlag_d;

  logic [7:0] sliceA, sliceB, sliceSum, sliceAnd, sliceOr, sliceXor;
  logic [7:0] sliceByte;
  logic       sliceCout;
  logic       subLike;
  logic       signedOvf;

  assign sliceA = opA_q[{byteIdx_q, 3'b000} +: 8];
  assign sliceB = opB_q[{byteIdx_q, 3'b000} +: 8];

  bit8_look_ahead_carry_adder uSlice (
    .A_in    (sliceA),
    .B_in    (sliceB),
    .C_in    (carry_q),
    .S_out   (sliceSum),
    .C_out   (sliceCout),
    .AND_out (sliceAnd),
    .OR_out  (sliceOr),
    .XOR_out (sliceXor)
  );

  // Subtract and both compares run as A + ~B + 1.
  assign subLike = (op_in == OP_SUB) || (op_in == OP_SLT) || (op_in == OP_SLTU);

  // Only meaningful on the top byte, where sliceSum[7] is the sign of the sum.
  assign signedOvf = (opA_q[W-1] == opB_q[W-1]) & (sliceSum[7] != opA_q[W-1]);

  // Pick which slice output is written into the current result byte.
  always_comb begin
    sliceByte = sliceSum;
    case (opCode_q)
      OP_AND:  sliceByte = sliceAnd;
      OP_OR:   sliceByte = sliceOr;
      OP_XOR:  sliceByte = sliceXor;
      OP_NOR:  sliceByte = ~sliceOr;
      default: sliceByte = sliceSum;
    endcase
  end

  // Next-state logic. IDLE latches the operands, BUSY walks the bytes and
  // forms the flags on the last byte, and DONE holds until downstream takes it.
  always_comb begin
    state_d     = state_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    opCode_d    = opCode_q;
    byteIdx_d   = byteIdx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    valid_d     = valid_q;
    zeroFlag_d  = zeroFlag_q;
    carryFlag_d = carryFlag_q;
    ovfFlag_d   = ovfFlag_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d   = BUSY;
          opA_d     = A_in;
          opB_d     = subLike ? ~B_in : B_in;
          opCode_d  = op_in;
          byteIdx_d = '0;
          carry_d   = subLike;
        end
      end
      BUSY: begin
        result_d[{byteIdx_q, 3'b000} +: 8] = sliceByte;
        carry_d   = sliceCout;
        byteIdx_d = byteIdx_q + IDX_W'(1);
        if (byteIdx_q == LAST_IDX) begin
          state_d     = DONE;
          valid_d     = 1'b1;
          carryFlag_d = 1'b0;
          ovfFlag_d   = 1'b0;
          case (opCode_q)
            OP_ADD, OP_SUB: begin
              carryFlag_d = sliceCout;
              ovfFlag_d   = signedOvf;
            end
`ifdef ALU_SEQ_SLT_EN
            OP_SLT: begin
              result_d    = {{(W-1){1'b0}}, sliceSum[7] ^ signedOvf};
              carryFlag_d = sliceCout;
              ovfFlag_d   = signedOvf;
            end
            OP_SLTU: begin
              result_d    = {{(W-1){1'b0}}, ~sliceCout};
              carryFlag_d = sliceCout;
            end
`else
            OP_SLT, OP_SLTU: begin
              result_d = '0;
            end
`endif
            default: begin
            end
          endcase
          zeroFlag_d = (result_d == '0);
        end
      end
      DONE: begin
        if (ready_in) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset wins over any handshake on the same
  // edge and clears the carry flop and byte index so no stale carry survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      opCode_q    <= '0;
      byteIdx_q   <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      zeroFlag_q  <= 1'b0;
      carryFlag_q <= 1'b0;
      ovfFlag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      opCode_q    <= opCode_d;
      byteIdx_q   <= byteIdx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      zeroFlag_q  <= zeroFlag_d;
      carryFlag_q <= carryFlag_d;
      ovfFlag_q   <= ovfFlag_d;
    end
  end

  assign ready_out    = (state_q == IDLE);
  assign result_out   = result_q;
  assign valid_out    = valid_q;
  assign zero_out     = zeroFlag_q;
  assign carry_out    = carryFlag_q;
  assign overflow_out = ovfFlag_q;

endmodule
